// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: entry layout and fetch FSM encodings.
package uart_pkg;

  localparam int unsigned UART_DW = 8;
  localparam int unsigned UART_EW = 10;

  localparam int unsigned UART_DATA_LSB = 0;
  localparam int unsigned UART_PERR_BIT = 8;
  localparam int unsigned UART_FERR_BIT = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_RELEASE = 2'd2
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
module uart_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW + 1)'(1);
  localparam logic [AW:0]   CntMax = (AW + 1)'(DEPTH);

  logic [Width-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntMax);
  assign count_o = count_q;

  // A read on empty is ignored; a write on full is accepted only if a read frees a slot.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Fetches bytes from the UART receiver with a one-cycle rdn strobe and buffers them
// with their error flags in a FWFT FIFO for the CPU.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic               clk16x,
  input  logic               clr,
  input  logic               r_ready,
  input  logic [UART_DW-1:0] rx_d,
  input  logic               rx_perr,
  input  logic               rx_ferr,
  output logic               rdn,
  input  logic               cpu_rd,
  output logic               q_valid,
  output logic [UART_DW-1:0] q_data,
  output logic               q_perr,
  output logic               q_ferr,
  output logic [AW:0]        count,
  output logic               full,
  output logic               overrun,
  input  logic               clr_ovr
);

  uart_state_e        state_q, state_d;
  logic               rdn_q, rdn_d;
  logic [UART_EW-1:0] cap_q, cap_d;
  logic               wr_pend_q, wr_pend_d;
  logic               ovr_q, ovr_d;
  logic               drop;
  logic               empty;
  logic [UART_EW-1:0] head;

  always_comb begin
    state_d   = state_q;
    rdn_d     = 1'b1;
    cap_d     = cap_q;
    wr_pend_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (r_ready) begin
          state_d = S_POP;
          rdn_d   = 1'b0;
        end
      end
      S_POP: begin
        cap_d     = {rx_ferr, rx_perr, rx_d};
        wr_pend_d = 1'b1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the receiver to drop ready so the same byte is not fetched twice.
        if (!r_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The captured byte is dropped only if the FIFO stays full through the write cycle.
  assign drop  = wr_pend_q & full & ~cpu_rd;
  assign ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);

  always_ff @(posedge clk16x) begin
    if (clr) begin
      state_q   <= S_IDLE;
      rdn_q     <= 1'b1;
      cap_q     <= '0;
      wr_pend_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdn_q     <= rdn_d;
      cap_q     <= cap_d;
      wr_pend_q <= wr_pend_d;
      ovr_q     <= ovr_d;
    end
  end

  uart_fifo #(
    .Width(UART_EW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk_i    (clk16x),
    .clr_i    (clr),
    .wr_en_i  (wr_pend_q),
    .wr_data_i(cap_q),
    .rd_en_i  (cpu_rd),
    .rd_data_o(head),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign rdn     = rdn_q;
  assign overrun = ovr_q;
  assign q_valid = ~empty;
  assign q_data  = head[UART_DATA_LSB +: UART_DW];
  assign q_perr  = head[UART_PERR_BIT];
  assign q_ferr  = head[UART_FERR_BIT];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of expected FIFO entries.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic       clk16x = 1'b0;
  logic       clr = 1'b1;
  logic       r_ready = 1'b0;
  logic [7:0] rx_d = '0;
  logic       rx_perr = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       rdn;
  logic       cpu_rd = 1'b0;
  logic       q_valid;
  logic [7:0] q_data;
  logic       q_perr;
  logic       q_ferr;
  logic [AW:0] count;
  logic       full;
  logic       overrun;
  logic       clr_ovr = 1'b0;

  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  logic exp_ovr = 1'b0;

  always #5 clk16x = ~clk16x;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk16x (clk16x),
    .clr    (clr),
    .r_ready(r_ready),
    .rx_d   (rx_d),
    .rx_perr(rx_perr),
    .rx_ferr(rx_ferr),
    .rdn    (rdn),
    .cpu_rd (cpu_rd),
    .q_valid(q_valid),
    .q_data (q_data),
    .q_perr (q_perr),
    .q_ferr (q_ferr),
    .count  (count),
    .full   (full),
    .overrun(overrun),
    .clr_ovr(clr_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_level();
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // Compare the head against the scoreboard and raise cpu_rd for the next edge.
  task automatic do_rd();
    logic [9:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_valid", 32'(q_valid), 32'd1);
      chk("q_data", 32'(q_data), 32'(e[7:0]));
      chk("q_flags", 32'({q_ferr, q_perr}), 32'(e[9:8]));
    end else begin
      chk("q_valid_empty", 32'(q_valid), 32'd0);
    end
    cpu_rd = 1'b1;
  endtask

  task automatic rd_one();
    do_rd();
    @(negedge clk16x);
    cpu_rd = 1'b0;
    chk_level();
  endtask

  // rd_at: 0 no read, 1 read during the POP cycle, 2 read during the write cycle.
  task automatic send(input logic [7:0] d, input logic pe, input logic fe,
                      input int hold, input int rd_at);
    bit acc;
    rx_d = d; rx_perr = pe; rx_ferr = fe; r_ready = 1'b1;
    @(negedge clk16x);
    chk("rdn_pop", 32'(rdn), 32'd0);
    if (rd_at == 1) do_rd();
    @(negedge clk16x);
    cpu_rd = 1'b0;
    chk("rdn_rel", 32'(rdn), 32'd1);
    acc = (sb.size() < DEPTH) || (rd_at == 2 && sb.size() > 0);
    if (rd_at == 2) do_rd();
    if (acc) sb.push_back({fe, pe, d});
    else exp_ovr = 1'b1;
    @(negedge clk16x);
    cpu_rd = 1'b0;
    chk_level();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk16x);
      chk("rdn_hold", 32'(rdn), 32'd1);
    end
    r_ready = 1'b0;
    @(negedge clk16x);
    chk("rdn_idle", 32'(rdn), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk16x);
    clr = 1'b0;
    chk("rst_rdn", 32'(rdn), 32'd1);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_data", 32'({q_ferr, q_perr, q_data}), 32'd0);
    chk_level();

    // Single byte with r_ready held long after the pop.
    send(8'hA5, 1'b0, 1'b0, 4, 0);
    rd_one();

    // Error flags travel with their bytes.
    send(8'h3C, 1'b1, 1'b0, 0, 0);
    send(8'h7E, 1'b0, 1'b1, 0, 0);
    rd_one();
    rd_one();

    // Fill, partial drain, refill across the pointer wrap, full drain.
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0, 1'b0, 0, 0);
    repeat (3) rd_one();
    for (int i = 8; i < 11; i++) send(8'(i), 1'b0, 1'b0, 0, 0);
    repeat (8) rd_one();

    // Overrun on the ninth byte, then clear it without touching contents.
    for (int i = 0; i < 9; i++) send(8'(8'h20 + i), 1'b0, 1'b0, 0, 0);
    clr_ovr = 1'b1;
    @(negedge clk16x);
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    chk_level();

    // Full with a read in the POP cycle, then in the write cycle: both writes kept.
    send(8'h40, 1'b0, 1'b0, 0, 1);
    send(8'h41, 1'b1, 1'b1, 0, 2);
    repeat (8) rd_one();
    chk("drained", 32'(q_valid), 32'd0);

    // Empty with a read in the write cycle: read ignored, byte kept.
    send(8'h55, 1'b0, 1'b1, 0, 2);
    rd_one();

    // Reset during POP drops the in-flight byte; a clean pop follows.
    send(8'h11, 1'b0, 1'b0, 0, 0);
    rx_d = 8'h99; r_ready = 1'b1;
    @(negedge clk16x);
    chk("rdn_pop_rst", 32'(rdn), 32'd0);
    clr = 1'b1;
    @(negedge clk16x);
    clr = 1'b0;
    sb.delete();
    exp_ovr = 1'b0;
    chk("rdn_after_rst", 32'(rdn), 32'd1);
    chk_level();
    send(8'h66, 1'b0, 1'b0, 0, 0);
    rd_one();
    chk("final_empty", 32'(q_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
